// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line constants and parity helper.
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;

  // 100 MHz system clock, 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic LINE_IDLE = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  // Callers zero-extend narrower words, which leaves the result unchanged.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_cnt.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_end on the final count.
module baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // clear dominates so a cleared counter never reports a bit end.
  assign bit_end = enable & ~clear & (count == LAST_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST_CNT) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 (or 8E1 when UART_TX_PARITY_EN is defined), LSB first, idle-high line.
// A one-entry hold register accepts the next byte during a frame so frames go out back to back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sig_tx,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_START  = 3'(START);
  localparam logic [2:0] S_DATA   = 3'(DATA);
  localparam logic [2:0] S_STOP   = 3'(STOP);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(PARITY);
`endif

  logic [2:0]        state;
  logic [DATA_W-1:0] hold_reg;
  logic              hold_full;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic              bit_end;
  logic              handshake;
  logic              take;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  // Handshake: a byte transfers on a rising edge where tx_valid and tx_ready are both high;
  // tx_ready depends only on the hold register, never on tx_valid.
  assign tx_ready  = ~hold_full;
  assign handshake = tx_valid & tx_ready;
  assign busy      = (state != S_IDLE) | hold_full;
  assign state_dbg = state;

  // The FSM consumes the hold byte from IDLE, or at the end of a stop bit for a gapless next frame.
  assign take = hold_full & ((state == S_IDLE) | ((state == S_STOP) & bit_end));

  baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == S_IDLE),
    .enable (1'b1),
    .bit_end(bit_end)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (handshake) begin
      hold_reg  <= tx_data;
      hold_full <= 1'b1;
    end else if (take) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sig_tx     <= LINE_IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          sig_tx <= LINE_IDLE;
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            sig_tx  <= shift_reg[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state  <= S_PARITY;
              sig_tx <= parity_bit;
`else
              state  <= S_STOP;
              sig_tx <= LINE_IDLE;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
              sig_tx    <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state  <= S_STOP;
            sig_tx <= LINE_IDLE;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          sig_tx <= LINE_IDLE;
        end
      endcase

      // Loading a new frame overrides the IDLE/STOP handling above.
      if (take) begin
        state     <= S_START;
        sig_tx    <= ~LINE_IDLE;
        shift_reg <= hold_reg;
`ifdef UART_TX_PARITY_EN
        parity_bit <= even_parity(32'(hold_reg));
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: fixed frame vectors, back-to-back and reset sequences at
// CLKS_PER_BIT=4, and a random byte stream at CLKS_PER_BIT=2 decoded by a bench receiver.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FL     = FRAME_BITS * CPB;
  localparam int NV     = 6;
  localparam int NRAND  = 50;

  // Clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [7:0] d4, d2;
  logic       v4, v2;
  logic       r4, s4, b4, r2, s2, b2;
  logic [2:0] st4, st2;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .tx_data(d4), .tx_valid(v4),
    .tx_ready(r4), .sig_tx(s4), .busy(b4), .state_dbg(st4)
  );

  uart_tx #(.CLKS_PER_BIT(CPB2), .DATA_W(8)) dut2 (
    .clock(clock), .reset(reset), .tx_data(d2), .tx_valid(v2),
    .tx_ready(r2), .sig_tx(s2), .busy(b2), .state_dbg(st2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: the line level for every clock of a frame, built from the frame rules.
  logic line_q[$];

  function automatic void model_frame(input logic [7:0] b, input int cpb);
    for (int c = 0; c < cpb; c++) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < cpb; c++) line_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < cpb; c++) line_q.push_back(^b);
`endif
    for (int c = 0; c < cpb; c++) line_q.push_back(1'b1);
  endfunction

  // Vector table: bits[k] is the k-th bit on the line (start, data LSB first, [parity], stop).
  typedef struct {
    logic [7:0]            data;
    logic [FRAME_BITS-1:0] bits;
  } vec_t;
  vec_t vecs[NV];

  task automatic run_vector(input vec_t v);
    logic [CPB-1:0] pat;
    @(negedge clock);
    v4 = 1'b1;
    d4 = v.data;
    @(negedge clock);
    v4 = 1'b0;
    d4 = ~v.data;
    check($sformatf("vec_%0h_ready_low", v.data), r4, 1'b0);
    check($sformatf("vec_%0h_line_pre", v.data), s4, 1'b1);
    check($sformatf("vec_%0h_busy_pre", v.data), b4, 1'b1);
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clock);
        pat[c] = s4;
        if (b == 0 && c == 0) check($sformatf("vec_%0h_ready_back", v.data), r4, 1'b1);
      end
      check($sformatf("vec_%0h_bit%0d", v.data, b), pat, {CPB{v.bits[b]}});
    end
    check($sformatf("vec_%0h_busy_last", v.data), b4, 1'b1);
    @(negedge clock);
    check($sformatf("vec_%0h_busy_done", v.data), b4, 1'b0);
    check($sformatf("vec_%0h_line_done", v.data), s4, 1'b1);
  endtask

  task automatic run_b2b();
    logic got_q[$];
    int   stall_bad;
    int   nmis;
    int   total;
    line_q.delete();
    model_frame(8'h00, CPB);
    model_frame(8'hFF, CPB);
    model_frame(8'h11, CPB);
    total = line_q.size();
    stall_bad = 0;
    @(negedge clock);
    v4 = 1'b1;
    d4 = 8'h00;
    @(negedge clock);
    check("b2b_ready_first", r4, 1'b0);
    d4 = 8'hFF;
    for (int k = 1; k <= total; k++) begin
      @(negedge clock);
      got_q.push_back(s4);
      if (k == 1) check("b2b_ready_start1", r4, 1'b1);
      if (k == 2) check("b2b_accept2", r4, 1'b0);
      if (k >= 3 && k <= FL) begin
        if (r4 !== 1'b0) stall_bad++;
        d4 = 8'($urandom);
      end
      if (k == FL + 1) begin
        check("b2b_ready_frame2", r4, 1'b1);
        d4 = 8'h11;
      end
      if (k == FL + 2) begin
        check("b2b_accept3", r4, 1'b0);
        v4 = 1'b0;
      end
    end
    check("b2b_stall", stall_bad, 0);
    nmis = 0;
    for (int i = 0; i < total; i++)
      if (got_q[i] !== line_q[i]) nmis++;
    check("b2b_line_mismatches", nmis, 0);
    @(negedge clock);
    check("b2b_busy_done", b4, 1'b0);
  endtask

  task automatic run_reset_mid_frame();
    int bad;
    @(negedge clock);
    v4 = 1'b1;
    d4 = 8'h3C;
    @(negedge clock);
    d4 = 8'h99;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (k == 2) v4 = 1'b0;
    end
    check("rst_hold_full_before", r4, 1'b0);
    check("rst_busy_before", b4, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_line", s4, 1'b1);
    check("rst_busy", b4, 1'b0);
    check("rst_ready", r4, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (s4 !== 1'b1 || b4 !== 1'b0) bad++;
    end
    check("rst_quiet_100", bad, 0);
  endtask

  // Scoreboard for the random stream.
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_err = 0;
  logic       rx_en = 1'b0;

  // Bench receiver: samples the last clock of each bit period of the CPB2 instance.
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge clock);
      if (rx_en && s2 === 1'b0) begin
        repeat (CPB2 - 1) @(negedge clock);
        if (s2 !== 1'b0) rx_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB2) @(negedge clock);
          rb[i] = s2;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB2) @(negedge clock);
        if (s2 !== ^rb) rx_err++;
`endif
        repeat (CPB2) @(negedge clock);
        if (s2 !== 1'b1) rx_err++;
        rx_q.push_back(rb);
      end
    end
  end

  task automatic run_random();
    int w;
    rx_en = 1'b1;
    for (int n = 0; n < NRAND; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      v2 = 1'b1;
      d2 = 8'($urandom);
      w = 0;
      while (r2 !== 1'b1 && w < 200) begin
        @(negedge clock);
        w++;
      end
      if (w >= 200) begin
        check("rand_ready_timeout", w, 0);
        break;
      end
      exp_q.push_back(d2);
      @(negedge clock);
      v2 = 1'b0;
    end
    w = 0;
    while (rx_q.size() < exp_q.size() && w < 5000) begin
      @(negedge clock);
      w++;
    end
    repeat (10) @(negedge clock);
    check("rand_count", rx_q.size(), exp_q.size());
    check("rand_rx_framing", rx_err, 0);
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("rand_byte%0d", i), rx_q[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h07, 11'b1_1_00000111_0};
    vecs[2] = '{8'h01, 11'b1_1_00000001_0};
    vecs[3] = '{8'h3C, 11'b1_0_00111100_0};
    vecs[4] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[5] = '{8'h5A, 11'b1_0_01011010_0};
`else
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h07, 10'b1_00000111_0};
    vecs[2] = '{8'h01, 10'b1_00000001_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'hFF, 10'b1_11111111_0};
    vecs[5] = '{8'h5A, 10'b1_01011010_0};
`endif
    reset = 1'b1;
    v4 = 1'b0;
    v2 = 1'b0;
    d4 = 8'h00;
    d2 = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_line", s4, 1'b1);
    check("reset_busy", b4, 1'b0);
    check("reset_ready", r4, 1'b1);
    check("reset_line2", s2, 1'b1);
    check("reset_busy2", b2, 1'b0);
    check("reset_ready2", r2, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      run_vector(vecs[i]);
      repeat (2) @(negedge clock);
    end
    run_b2b();
    repeat (3) @(negedge clock);
    run_reset_mid_frame();
    run_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serialises bytes onto the `sig_tx` UART line, 8N1 format, LSB first, line idle high.
- Sits beside the receive path in the top level. The core delivers reply bytes over a valid/ready handshake.
- A one-entry hold register lets the next byte be accepted during the current frame, so consecutive frames go out with no idle gap.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200). Legal range is 2 or more.
- DATA_W, 8, data bits per frame.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_W  byte to send; sampled on handshake.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  hold register empty; the byte is accepted when tx_valid and tx_ready are both high at a rising edge.
- sig_tx  out  1  serial output.
- busy  out  1  a frame is on the line (FSM not in IDLE), or the hold register is full.

Behaviour:
- Reset values (asynchronous): sig_tx=1, busy=0, hold_full=0, FSM=IDLE, baud counter=0, bit index=0.
- tx_ready = !hold_full, combinational, so it reads 1 during reset.
- Hold register:
  - Loaded on handshake, which sets hold_full.
  - Cleared when the FSM takes the byte.
  - No write/read conflict is possible, because ready is low while full.
- FSM states: IDLE, START, DATA, STOP (PARITY with PARITY_EN).
  - IDLE, hold_full=1: on the next edge load the shift register from hold, clear hold_full, enter START, counter=0. sig_tx=0 from that edge.
  - START, DATA, STOP each hold their line value for exactly CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1, and the state advances on count == CLKS_PER_BIT-1.
  - DATA: sig_tx = shift[0]; the register shifts right at each bit end. Bit index runs 0..DATA_W-1, then the FSM goes to STOP (or PARITY).
  - STOP: sig_tx=1. At bit end:
    - hold_full=1: go directly to START and load the hold byte (back-to-back, zero idle cycles).
    - otherwise: go to IDLE.
- Latency: handshake at edge N, start bit begins at edge N+1 when IDLE. Frame length is (2+DATA_W)*CLKS_PER_BIT cycles, 40 for DATA_W=8 and CLKS_PER_BIT=4.
- sig_tx is registered and glitch-free.
- A second handshake is accepted one cycle after the FSM consumes hold, i.e. during the start bit.
- tx_data changes while not handshaking are ignored.
- Reset mid-frame: the line returns to 1 immediately, the pending hold byte is discarded, and no partial frame resumes.
- tx_valid held high with constant data sends repeated frames continuously.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - sig_tx = even parity (XOR of all data bits) for CLKS_PER_BIT cycles.
  - Frame is (3+DATA_W)*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, 8N1 only; the parity XOR logic is not synthesised.

Decomposition:
- Package uart_pkg holds:
  - the `tx_state_t` enum (IDLE, START, DATA, STOP, PARITY);
  - localparams for the default CLKS_PER_BIT and the idle line level;
  - a shared function computing even parity.
- Sub-module baud_cnt (counter with clear input and bit_end pulse), shared with the receiver.
- FSM, shifter and hold register live in uart_tx.

Test Plan:
- CLKS_PER_BIT=4, single 0xA5 → sig_tx held 4 cycles each: 0,1,0,1,0,0,1,0,1,1. Start bit at edge N+1, busy low 40 cycles later, tx_ready low for exactly 1 cycle.
- Back-to-back 0x00 then 0xFF (tx_valid kept high) → 80 contiguous cycles: 0, eight 0, 1, 0, eight 1, 1. No idle cycle between frames. The second byte is accepted during the first start bit; the third handshake stalls until the second frame starts.
- tx_valid pulsed with tx_ready=0 (hold full) → byte not accepted, output frames unchanged.
- Reset asserted at cycle 15 of a 0x3C frame → sig_tx=1, busy=0, tx_ready=1 immediately. After release with no new handshake, the line stays 1 for 100 cycles.
- UART_TX_PARITY_EN, 0x07 → parity bit 1; 0xA5 → parity bit 0; frame 44 cycles each.
- CLKS_PER_BIT=2 (minimum), random 50 bytes → a bench receiver model recovers every byte in order.
